// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller for a 5-stage in-order core.
// Handles mul/div multi-cycle EX occupancy, EX redirects and load-use stalls.
// Also keeps a saturating count of the cycles in which the PC was held.
// MULDIV_LAT is the total EX occupancy of a mul/div op; legal range is 2..16.
module pipeline_hazard_ctrl #(
   parameter int MULDIV_LAT = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  id_rs1,
   input  logic [4:0]  id_rs2,
   input  logic        id_uses_rs1,
   input  logic        id_uses_rs2,
   input  logic [4:0]  ex_rd,
   input  logic        ex_mem_read,
   input  logic        ex_redirect,
   input  logic        ex_muldiv_start,
   output logic        pc_stall,
   output logic        if_id_stall,
   output logic        id_ex_stall,
   output logic        if_id_flush,
   output logic        id_ex_flush,
   output logic        ex_mem_flush,
   output logic        busy,
   output logic        muldiv_done,
   output logic [15:0] stall_count
);

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   state_t      state;
   state_t      state_next;
   logic [3:0]  cnt;
   logic [3:0]  cnt_next;
   logic        load_use;

   // The start cycle is already one cycle of the sequence, and the final
   // BUSY cycle is the one with cnt=0, so BUSY begins at MULDIV_LAT-2.
   localparam logic [3:0] CNT_START = 4'(MULDIV_LAT - 2);

   // A load in EX feeding a source the ID instruction actually reads; x0 never counts.
   always_comb begin
      load_use = 1'b0;
      if (ex_mem_read && (ex_rd != 5'd0)) begin
         load_use = (id_uses_rs1 && (id_rs1 == ex_rd)) ||
                    (id_uses_rs2 && (id_rs2 == ex_rd));
      end
   end

   // Next-state and control outputs; reset forces every control output low.
   always_comb begin
      state_next   = state;
      cnt_next     = cnt;
      pc_stall     = 1'b0;
      if_id_stall  = 1'b0;
      id_ex_stall  = 1'b0;
      if_id_flush  = 1'b0;
      id_ex_flush  = 1'b0;
      ex_mem_flush = 1'b0;
      busy         = 1'b0;
      muldiv_done  = 1'b0;
      if (rst) begin
         case (state)
            IDLE: begin
               if (ex_muldiv_start) begin
                  pc_stall     = 1'b1;
                  if_id_stall  = 1'b1;
                  id_ex_stall  = 1'b1;
                  ex_mem_flush = 1'b1;
                  busy         = 1'b1;
                  state_next   = BUSY;
                  cnt_next     = CNT_START;
               end else if (ex_redirect) begin
                  if_id_flush = 1'b1;
                  id_ex_flush = 1'b1;
               end else if (load_use) begin
                  pc_stall    = 1'b1;
                  if_id_stall = 1'b1;
                  id_ex_flush = 1'b1;
               end
            end
            BUSY: begin
               pc_stall     = 1'b1;
               if_id_stall  = 1'b1;
               id_ex_stall  = 1'b1;
               ex_mem_flush = 1'b1;
               busy         = 1'b1;
               if (cnt == 4'd0) begin
                  muldiv_done = 1'b1;
                  state_next  = IDLE;
               end else begin
                  cnt_next = cnt - 4'd1;
               end
            end
            default: begin
               state_next = IDLE;
               cnt_next   = 4'd0;
            end
         endcase
      end
   end

   // State and down-counter registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= IDLE;
         cnt   <= 4'd0;
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
      end
   end

   // Saturating count of cycles in which the PC was held.
   always_ff @(posedge clk) begin
      if (!rst) begin
         stall_count <= 16'd0;
      end else if (pc_stall && (stall_count != 16'hFFFF)) begin
         stall_count <= stall_count + 16'd1;
      end
   end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl (MULDIV_LAT = 4).
// Table-driven single-cycle vectors plus hand-written multi-cycle sequences.
module tb_pipeline_hazard_ctrl;

   logic        clk;
   logic        rst;
   logic [4:0]  id_rs1;
   logic [4:0]  id_rs2;
   logic        id_uses_rs1;
   logic        id_uses_rs2;
   logic [4:0]  ex_rd;
   logic        ex_mem_read;
   logic        ex_redirect;
   logic        ex_muldiv_start;
   logic        pc_stall;
   logic        if_id_stall;
   logic        id_ex_stall;
   logic        if_id_flush;
   logic        id_ex_flush;
   logic        ex_mem_flush;
   logic        busy;
   logic        muldiv_done;
   logic [15:0] stall_count;

   int          checks;
   int          failures;
   logic [15:0] model_count;

   // Output bundle: {pc_stall, if_id_stall, id_ex_stall, if_id_flush,
   //                 id_ex_flush, ex_mem_flush, busy, muldiv_done}
   localparam logic [7:0] NONE     = 8'b000_00_000;
   localparam logic [7:0] LU       = 8'b110_01_000;
   localparam logic [7:0] RD       = 8'b000_11_000;
   localparam logic [7:0] MD       = 8'b111_00_110;
   localparam logic [7:0] MD_LAST  = 8'b111_00_111;

   typedef struct {
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic       u1;
      logic       u2;
      logic [4:0] rd;
      logic       mem_read;
      logic       redirect;
      logic       md_start;
      logic [7:0] exp;
   } vec_t;

   vec_t tbl [9];

   pipeline_hazard_ctrl #(.MULDIV_LAT(4)) dut (
      .clk             (clk),
      .rst             (rst),
      .id_rs1          (id_rs1),
      .id_rs2          (id_rs2),
      .id_uses_rs1     (id_uses_rs1),
      .id_uses_rs2     (id_uses_rs2),
      .ex_rd           (ex_rd),
      .ex_mem_read     (ex_mem_read),
      .ex_redirect     (ex_redirect),
      .ex_muldiv_start (ex_muldiv_start),
      .pc_stall        (pc_stall),
      .if_id_stall     (if_id_stall),
      .id_ex_stall     (id_ex_stall),
      .if_id_flush     (if_id_flush),
      .id_ex_flush     (id_ex_flush),
      .ex_mem_flush    (ex_mem_flush),
      .busy            (busy),
      .muldiv_done     (muldiv_done),
      .stall_count     (stall_count)
   );

   // Free-running 10-unit clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic vec_t mk(input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic u1, input logic u2, input logic [4:0] rd,
                               input logic mr, input logic rdr, input logic ms,
                               input logic [7:0] exp);
      vec_t v;
      v.rs1 = rs1; v.rs2 = rs2; v.u1 = u1; v.u2 = u2; v.rd = rd;
      v.mem_read = mr; v.redirect = rdr; v.md_start = ms; v.exp = exp;
      return v;
   endfunction

   // Drive one vector shortly after the falling edge.
   task automatic applyStimulus(input vec_t v);
      @(negedge clk);
      id_rs1          = v.rs1;
      id_rs2          = v.rs2;
      id_uses_rs1     = v.u1;
      id_uses_rs2     = v.u2;
      ex_rd           = v.rd;
      ex_mem_read     = v.mem_read;
      ex_redirect     = v.redirect;
      ex_muldiv_start = v.md_start;
   endtask

   // Check combinational outputs mid-cycle, then stall_count after the next edge.
   task automatic checkOutput(input string name, input logic [7:0] exp);
      logic [7:0] act;
      #1;
      act = {pc_stall, if_id_stall, id_ex_stall, if_id_flush,
             id_ex_flush, ex_mem_flush, busy, muldiv_done};
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s outputs: got %b expected %b", name, act, exp);
      end
      if (!rst) model_count = 16'd0;
      else if (exp[7] && model_count != 16'hFFFF) model_count = model_count + 16'd1;
      @(posedge clk);
      #1;
      checks++;
      if (stall_count !== model_count) begin
         failures++;
         $display("[TB] FAIL %s stall_count: got %0d expected %0d", name, stall_count, model_count);
      end
   endtask

   initial begin
      vec_t idle_v;
      vec_t noisy_v;

      checks      = 0;
      failures    = 0;
      model_count = 16'd0;

      idle_v  = mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, NONE);
      noisy_v = mk(5'd5, 5'd5, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1, 1'b1, NONE);

      tbl[0] = mk(5'd3,  5'd5,  1'b1, 1'b1, 5'd5,  1'b1, 1'b0, 1'b0, LU);
      tbl[1] = mk(5'd0,  5'd5,  1'b1, 1'b1, 5'd0,  1'b1, 1'b0, 1'b0, NONE);
      tbl[2] = mk(5'd7,  5'd1,  1'b0, 1'b1, 5'd7,  1'b1, 1'b0, 1'b0, NONE);
      tbl[3] = mk(5'd7,  5'd1,  1'b1, 1'b0, 5'd7,  1'b1, 1'b0, 1'b0, LU);
      tbl[4] = mk(5'd7,  5'd7,  1'b1, 1'b1, 5'd7,  1'b0, 1'b0, 1'b0, NONE);
      tbl[5] = mk(5'd2,  5'd3,  1'b1, 1'b1, 5'd9,  1'b0, 1'b1, 1'b0, RD);
      tbl[6] = mk(5'd9,  5'd3,  1'b1, 1'b1, 5'd9,  1'b1, 1'b1, 1'b0, RD);
      tbl[7] = mk(5'd4,  5'd12, 1'b1, 1'b0, 5'd12, 1'b1, 1'b0, 1'b0, NONE);
      tbl[8] = mk(5'd31, 5'd31, 1'b1, 1'b1, 5'd31, 1'b1, 1'b0, 1'b0, LU);

      // Reset held with every hazard input active: outputs forced low.
      rst = 1'b0;
      applyStimulus(noisy_v);
      checkOutput("reset_forced_low", NONE);
      applyStimulus(noisy_v);
      checkOutput("reset_forced_low2", NONE);

      rst = 1'b1;
      applyStimulus(idle_v);
      checkOutput("idle_after_reset", NONE);

      // Single-cycle table.
      for (int i = 0; i < 9; i++) begin
         applyStimulus(tbl[i]);
         checkOutput($sformatf("vec%0d", i), tbl[i].exp);
      end

      // Mul/div sequence; hazards and a new start during BUSY are ignored.
      applyStimulus(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, MD));
      checkOutput("md_c1", MD);
      applyStimulus(noisy_v);
      checkOutput("md_c2", MD);
      applyStimulus(noisy_v);
      checkOutput("md_c3", MD);
      applyStimulus(noisy_v);
      checkOutput("md_c4_done", MD_LAST);
      applyStimulus(idle_v);
      checkOutput("md_after", NONE);

      // Mul/div start wins over a coincident redirect and load-use.
      applyStimulus(noisy_v);
      checkOutput("prio_md_c1", MD);
      applyStimulus(idle_v);
      checkOutput("prio_md_c2", MD);
      applyStimulus(idle_v);
      checkOutput("prio_md_c3", MD);
      applyStimulus(idle_v);
      checkOutput("prio_md_c4", MD_LAST);
      applyStimulus(idle_v);
      checkOutput("prio_md_after", NONE);

      // Reset during the second BUSY cycle aborts with no done pulse.
      applyStimulus(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, MD));
      checkOutput("abort_c1", MD);
      applyStimulus(idle_v);
      rst = 1'b0;
      checkOutput("abort_rst", NONE);
      applyStimulus(idle_v);
      rst = 1'b1;
      checkOutput("abort_resume", NONE);
      applyStimulus(tbl[0]);
      checkOutput("abort_lu_after", LU);

      // Saturation: hold a load-use hazard well past 16'hFFFF stall cycles.
      rst = 1'b0;
      applyStimulus(idle_v);
      checkOutput("sat_reset", NONE);
      rst = 1'b1;
      applyStimulus(tbl[0]);
      for (int i = 0; i < 65535 - 1; i++) @(posedge clk);
      #1;
      checks++;
      if (stall_count !== 16'hFFFE) begin
         failures++;
         $display("[TB] FAIL sat_near: got %h expected %h", stall_count, 16'hFFFE);
      end
      for (int i = 0; i < 4; i++) @(posedge clk);
      #1;
      checks++;
      if (stall_count !== 16'hFFFF) begin
         failures++;
         $display("[TB] FAIL sat_hold: got %h expected %h", stall_count, 16'hFFFF);
      end
      model_count = 16'hFFFF;
      checkOutput("sat_still_stalling", LU);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
